// File: rtl/debug_display_ctrl.sv
// Debug display controller: shows one 32-bit debug channel on seven-segment
// digits. Channel and digit window are chosen with debounced pushbuttons or
// by auto-scroll. A freeze input holds the displayed snapshot.
module debug_display_ctrl #(
  parameter int NUM_CH          = 4,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int SCROLL_CYCLES   = 125000000
) (
  input  logic                                              external_clk,
  input  logic                                              rst,
  input  logic [NUM_CH*32-1:0]                              ch_data,
  input  logic                                              key_next_n,
  input  logic                                              key_win_n,
  input  logic                                              auto_mode,
  input  logic                                              freeze,
  output logic [NUM_DIGITS*7-1:0]                           hex_out,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    ch_sel,
  output logic [(((8/NUM_DIGITS) > 1) ? $clog2(8/NUM_DIGITS) : 1)-1:0] win_sel
);

  localparam int WINDOWS = 8 / NUM_DIGITS;
  localparam int WIN_BITS = NUM_DIGITS * 4;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WIN_W = (WINDOWS > 1) ? $clog2(WINDOWS) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W  = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CH - 1);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(WINDOWS - 1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(SCROLL_CYCLES - 1);

  // Active-low segment code, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Index 0 is the next-channel key, index 1 the next-window key
  logic [1:0]            r_sync1, r_sync2, r_lvl;
  logic [DB_W-1:0]       r_db_cnt [2];
  logic [1:0]            w_press;
  logic [SC_W-1:0]       r_scroll_cnt;
  logic                  w_tick, w_ch_step;
  logic [CH_W-1:0]       r_ch_sel;
  logic                  r_sel_upd;
  logic [WIN_W-1:0]      r_win_sel, r_win_d;
  logic [31:0]           r_snap, w_sel_data;
  logic [WIN_BITS-1:0]   w_win_bits;
  logic [NUM_DIGITS*7-1:0] w_hex_next, r_hex;

  // Two-flop synchronizers for the raw pushbuttons (idle high)
  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= {key_win_n, key_next_n};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES disagreeing samples in a row
  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) begin
      r_lvl <= 2'b11;
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_lvl[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_MAX) begin
          r_lvl[k]    <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Press pulse fires on the same cycle the accepted level falls to 0
  assign w_press   = r_lvl & ~r_sync2 & {(r_db_cnt[1] == DB_MAX), (r_db_cnt[0] == DB_MAX)};
  assign w_tick    = auto_mode & (r_scroll_cnt == SC_MAX);
  assign w_ch_step = w_press[0] | w_tick;

  // Auto-scroll period counter; any channel step restarts the period
  always_ff @(posedge external_clk or posedge rst) begin
    if (rst)                        r_scroll_cnt <= '0;
    else if (!auto_mode || w_ch_step) r_scroll_cnt <= '0;
    else                            r_scroll_cnt <= r_scroll_cnt + SC_W'(1);
  end

  // Channel select; a coincident press and tick still advance by one
  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) begin
      r_ch_sel  <= '0;
      r_sel_upd <= 1'b0;
    end else begin
      r_sel_upd <= w_ch_step && (NUM_CH > 1);
      if (w_ch_step) r_ch_sel <= (r_ch_sel == CH_MAX) ? '0 : r_ch_sel + CH_W'(1);
    end
  end

  // Window select, delayed one cycle so it lines up with the snapshot stage
  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) begin
      r_win_sel <= '0;
      r_win_d   <= '0;
    end else begin
      if (w_press[1]) r_win_sel <= (r_win_sel == WIN_MAX) ? '0 : r_win_sel + WIN_W'(1);
      r_win_d <= r_win_sel;
    end
  end

  // Mux the selected channel out of the flat input bus
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (r_ch_sel == CH_W'(k)) w_sel_data = ch_data[32*k +: 32];
  end

  // Stage 1: snapshot; frozen unless the channel just changed
  always_ff @(posedge external_clk or posedge rst) begin
    if (rst)                       r_snap <= '0;
    else if (!freeze || r_sel_upd) r_snap <= w_sel_data;
  end

  // Pick the digit window and encode each nibble
  always_comb begin
    w_win_bits = '0;
    for (int w = 0; w < WINDOWS; w++)
      if (r_win_d == WIN_W'(w)) w_win_bits = r_snap[w*WIN_BITS +: WIN_BITS];
    w_hex_next = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      w_hex_next[7*d +: 7] = seg7(w_win_bits[4*d +: 4]);
  end

  // Stage 2: registered segment outputs, blank during reset
  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) r_hex <= '1;
    else     r_hex <= w_hex_next;
  end

  assign hex_out = r_hex;
  assign ch_sel  = r_ch_sel;
  assign win_sel = r_win_sel;

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Self-checking bench for debug_display_ctrl (4 channels, 4 digits,
// short debounce and scroll periods).
module tb_debug_display_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ch_data;
  logic         key_next_n = 1'b1;
  logic         key_win_n  = 1'b1;
  logic         auto_mode  = 1'b0;
  logic         freeze     = 1'b0;
  logic [27:0]  hex_out;
  logic [1:0]   ch_sel;
  logic [0:0]   win_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [27:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [27:0] sbq [$];
  logic [27:0] exp_hex;

  always #5 clk = ~clk;

  debug_display_ctrl #(
    .NUM_CH(4), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .SCROLL_CYCLES(8)
  ) dut (
    .external_clk(clk), .rst(rst), .ch_data(ch_data),
    .key_next_n(key_next_n), .key_win_n(key_win_n),
    .auto_mode(auto_mode), .freeze(freeze),
    .hex_out(hex_out), .ch_sel(ch_sel), .win_sel(win_sel)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [27:0] enc16(input logic [15:0] v);
    return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_next(input int len);
    key_next_n = 1'b0;
    tick(len);
    key_next_n = 1'b1;
    tick(10);
  endtask

  task automatic press_win(input int len);
    key_win_n = 1'b0;
    tick(len);
    key_win_n = 1'b1;
    tick(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[1] = '{32'hFFFF_FFFF, {7'h0E, 7'h0E, 7'h0E, 7'h0E}};
    vecs[2] = '{32'h1234_5678, {7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[3] = '{32'h0000_ABCD, enc16(16'hABCD)};
    vecs[4] = '{32'hDEAD_BEEF, enc16(16'hBEEF)};
    vecs[5] = '{32'h0000_0123, enc16(16'h0123)};

    ch_data = {32'h55AA_33CC, 32'h0F1E_2D3C, 32'h9ABC_DEF0, 32'h1234_5678};

    // reset state
    tick(3);
    chk("rst_hex", hex_out, 28'hFFF_FFFF);
    chk("rst_ch", ch_sel, 0);
    chk("rst_win", win_sel, 0);
    rst = 1'b0;
    tick(2);
    chk("post_rst_hex", hex_out, {7'h12, 7'h02, 7'h78, 7'h00});

    // streamed vectors on channel 0, one per cycle, scoreboard ordered
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        ch_data[31:0] = vecs[i].data;
        sbq.push_back(vecs[i].exp);
      end
      tick(1);
      if (i >= 1) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          exp_hex = sbq.pop_front();
          chk("vec_hex", hex_out, exp_hex);
        end
      end
    end
    ch_data[31:0] = 32'h1234_5678;
    tick(3);

    // debounce: short glitch ignored, long press accepted once
    press_next(3);
    chk("db_short", ch_sel, 0);
    press_next(10);
    chk("db_long", ch_sel, 1);
    chk("db_hex", hex_out, enc16(16'hDEF0));

    // channel wrap
    press_next(10); chk("wrap2", ch_sel, 2);
    press_next(10); chk("wrap3", ch_sel, 3);
    press_next(10); chk("wrap0", ch_sel, 0);

    // window wrap, upper then lower half of channel 0
    press_win(10);
    chk("win1", win_sel, 1);
    chk("win1_hex", hex_out, enc16(16'h1234));
    press_win(10);
    chk("win0", win_sel, 0);
    chk("win0_hex", hex_out, enc16(16'h5678));

    // auto-scroll every 8 cycles
    auto_mode = 1'b1;
    tick(7); chk("as_pre1", ch_sel, 0);
    tick(1); chk("as_t1", ch_sel, 1);
    tick(7); chk("as_pre2", ch_sel, 1);
    tick(1); chk("as_t2", ch_sel, 2);
    // press pulse lands exactly on the next tick
    tick(2);
    key_next_n = 1'b0;
    tick(5); chk("as_co_pre", ch_sel, 2);
    tick(1); chk("as_co", ch_sel, 3);
    key_next_n = 1'b1;
    tick(7); chk("as_co_next_pre", ch_sel, 3);
    tick(1); chk("as_co_next", ch_sel, 0);
    // press between ticks restarts the period
    key_next_n = 1'b0;
    tick(6);
    key_next_n = 1'b1;
    chk("as_mid_press", ch_sel, 1);
    tick(2); chk("as_restart", ch_sel, 1);
    tick(5); chk("as_restart_pre", ch_sel, 1);
    tick(1); chk("as_restart_tick", ch_sel, 2);
    auto_mode = 1'b0;
    tick(10);
    chk("as_off", ch_sel, 2);
    press_next(10);
    press_next(10);
    chk("back_to_0", ch_sel, 0);

    // freeze
    ch_data[31:0] = 32'hAAAA_0000;
    tick(3);
    chk("frz_pre", hex_out, enc16(16'h0000));
    freeze = 1'b1;
    ch_data[31:0] = 32'h0000_BBBB;
    tick(3);
    chk("frz_hold", hex_out, enc16(16'h0000));
    ch_data[63:32] = 32'h1357_2468;
    press_next(10);
    chk("frz_ch", ch_sel, 1);
    chk("frz_load", hex_out, enc16(16'h2468));
    ch_data[63:32] = 32'hFFFF_0000;
    tick(3);
    chk("frz_hold2", hex_out, enc16(16'h2468));
    freeze = 1'b0;
    tick(3);
    chk("frz_off", hex_out, enc16(16'h0000));

    // asynchronous reset mid-scroll and mid-debounce
    press_win(10);
    chk("ar_win_pre", win_sel, 1);
    auto_mode = 1'b1;
    tick(3);
    key_next_n = 1'b0;
    tick(3);
    rst = 1'b1;
    #1;
    chk("ar_hex", hex_out, 28'hFFF_FFFF);
    chk("ar_ch", ch_sel, 0);
    chk("ar_win", win_sel, 0);
    tick(3);
    key_next_n = 1'b1;
    auto_mode  = 1'b0;
    rst = 1'b0;
    tick(2);
    chk("ar_resume_hex", hex_out, enc16(16'hBBBB));
    tick(10);
    chk("ar_no_pulse", ch_sel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
